// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types
// Owner and halt-state encodings plus default widths.
package dmem_pkg;

  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } halt_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter bus interface
// CPU port, debug port, halt handshake and memory side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_stall;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              halt_req;
  logic              halt_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  halt_req, mem_rdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output halt_ack,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output halt_req, mem_rdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  halt_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter_halt_fsm.sv
// dmem_arbiter halt handshake
// Freezes CPU access; acks once no CPU read is outstanding.
module dmem_halt_fsm
  import dmem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   halt_req,
  input  logic   rsp_pend,
  input  owner_e rsp_owner,
  output logic   halt_ack,
  output logic   cpu_block
);

  halt_state_e state;
  logic        cpu_rd;

  // rsp_pend/rsp_owner describe the read in flight after this edge
  assign cpu_rd = rsp_pend && (rsp_owner == OWN_CPU);

  // halt state machine with registered ack and CPU block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      halt_ack  <= 1'b0;
      cpu_block <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_req) begin
            state     <= HALT_PEND;
            cpu_block <= 1'b1;
          end
        end
        HALT_PEND: begin
          if (!halt_req) begin
            state     <= RUN;
            cpu_block <= 1'b0;
          end else if (!cpu_rd) begin
            state    <= HALTED;
            halt_ack <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state     <= RUN;
            halt_ack  <= 1'b0;
            cpu_block <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          halt_ack  <= 1'b0;
          cpu_block <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter top
// CPU/debug arbitration for the single-port data memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int            CW   = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic          rsp_pend;
  owner_e        rsp_owner;
  logic          rsp_pend_nxt;
  owner_e        rsp_owner_nxt;
  logic          cpu_block;
  logic          c_win;
  logic          d_win;

  dmem_halt_fsm u_halt (
    .clk       (clk),
    .rst       (rst),
    .halt_req  (bus.halt_req),
    .rsp_pend  (rsp_pend_nxt),
    .rsp_owner (rsp_owner_nxt),
    .halt_ack  (bus.halt_ack),
    .cpu_block (cpu_block)
  );

  // grant: forced D, then C unless frozen, then D
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (bus.d_req && (starve_cnt == SMAX)) begin
        d_win = 1'b1;
      end else if (bus.c_req && !cpu_block) begin
        c_win = 1'b1;
      end else if (bus.d_req) begin
        d_win = 1'b1;
      end
    end
  end

  assign bus.c_gnt   = c_win;
  assign bus.d_gnt   = d_win;
  assign bus.c_stall = bus.c_req && !c_win && !rst;

  // memory strobes muxed from the winner, zero when idle
  always_comb begin
    bus.mem_en    = c_win | d_win;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (c_win) begin
      bus.mem_we    = bus.c_we;
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
    end else if (d_win) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  assign rsp_pend_nxt  = (c_win && !bus.c_we) ||
                         (d_win && !bus.d_we);
  assign rsp_owner_nxt = d_win ? OWN_DBG : OWN_CPU;

  // starvation counter and read-response owner tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      rsp_pend   <= 1'b0;
      rsp_owner  <= OWN_CPU;
    end else begin
      if (!bus.d_req || d_win) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SMAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      rsp_pend  <= rsp_pend_nxt;
      rsp_owner <= rsp_owner_nxt;
    end
  end

  assign bus.c_rvalid = rsp_pend && (rsp_owner == OWN_CPU);
  assign bus.d_rvalid = rsp_pend && (rsp_owner == OWN_DBG);
  assign bus.c_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// dmem_arbiter testbench
// Directed scenarios plus random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  typedef struct {
    bit            vld;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  bit   load;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] env_mem [32];

  // environment memory: registered read, one-cycle latency
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= ref_mem[i];
    end else if (bus.mem_en && bus.mem_we) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= env_mem[bus.mem_addr];
    end
  end

  txn_t ct, dt;
  bit   hreq;

  int            m_starve;
  int            m_mode;
  bit            m_rv;
  bit            m_rown;
  logic [DW-1:0] m_rdata;
  bit            m_cg, m_dg;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic txn_t mk(input bit we, input int addr,
                              input logic [DW-1:0] wd);
    txn_t t;
    t.vld   = 1'b1;
    t.we    = we;
    t.addr  = addr[AW-1:0];
    t.wdata = wd;
    return t;
  endfunction

  task automatic model_reset();
    m_starve = 0;
    m_mode   = 0;
    m_rv     = 1'b0;
  endtask

  task automatic step();
    logic [DW-1:0] ea, ew;
    bit            ewe;
    bit            inflight_c;
    bus.c_req    = ct.vld;
    bus.c_we     = ct.we;
    bus.c_addr   = ct.addr;
    bus.c_wdata  = ct.wdata;
    bus.d_req    = dt.vld;
    bus.d_we     = dt.we;
    bus.d_addr   = dt.addr;
    bus.d_wdata  = dt.wdata;
    bus.halt_req = hreq;
    @(negedge clk);
    m_cg = 1'b0;
    m_dg = 1'b0;
    if (!rst) begin
      if (dt.vld && m_starve == SMAX) m_dg = 1'b1;
      else if (ct.vld && m_mode == 0) m_cg = 1'b1;
      else if (dt.vld) m_dg = 1'b1;
    end
    ewe = m_cg ? ct.we : (m_dg ? dt.we : 1'b0);
    ea  = m_cg ? DW'(ct.addr) : (m_dg ? DW'(dt.addr) : '0);
    ew  = m_cg ? ct.wdata : (m_dg ? dt.wdata : '0);
    chk("c_gnt", bus.c_gnt, m_cg);
    chk("d_gnt", bus.d_gnt, m_dg);
    chk("c_stall", bus.c_stall, ct.vld && !m_cg && !rst);
    chk("mem_en", bus.mem_en, m_cg || m_dg);
    chk("mem_we", bus.mem_we, ewe);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ew);
    chk("c_rvalid", bus.c_rvalid, m_rv && !m_rown);
    chk("d_rvalid", bus.d_rvalid, m_rv && m_rown);
    if (m_rv && !m_rown) chk("c_rdata", bus.c_rdata, m_rdata);
    if (m_rv && m_rown) chk("d_rdata", bus.d_rdata, m_rdata);
    chk("halt_ack", bus.halt_ack, m_mode == 2);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (dt.vld && !m_dg) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
      m_rv = 1'b0;
      if (m_cg) begin
        if (ct.we) ref_mem[ct.addr] = ct.wdata;
        else begin
          m_rv    = 1'b1;
          m_rown  = 1'b0;
          m_rdata = ref_mem[ct.addr];
        end
        ct.vld = 1'b0;
      end
      if (m_dg) begin
        if (dt.we) ref_mem[dt.addr] = dt.wdata;
        else begin
          m_rv    = 1'b1;
          m_rown  = 1'b1;
          m_rdata = ref_mem[dt.addr];
        end
        dt.vld = 1'b0;
      end
      inflight_c = m_rv && !m_rown;
      case (m_mode)
        0: if (hreq) m_mode = 1;
        1: if (!hreq) m_mode = 0;
           else if (!inflight_c) m_mode = 2;
        default: if (!hreq) m_mode = 0;
      endcase
    end
    #1;
  endtask

  int dcyc;
  int cg_n;

  initial begin
    rst  = 1'b1;
    load = 1'b1;
    hreq = 1'b0;
    ct   = '{default: '0};
    dt   = '{default: '0};
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'd17;
    model_reset();
    step();
    load = 1'b0;
    step();
    rst = 1'b0;

    // single CPU read
    ct = mk(1'b0, 3, '0);
    step();
    step();
    chk("t1_rdata", bus.c_rdata, 32'd17);

    // starvation: D forced on the fifth contended cycle
    dt   = mk(1'b1, 7, 32'hAA);
    dcyc = 0;
    cg_n = 0;
    for (int i = 1; i <= 8 && dt.vld; i++) begin
      if (!ct.vld) ct = mk(1'b0, int'($urandom_range(0, 31)), '0);
      step();
      if (bus.c_gnt === 1'b1) cg_n++;
      if (m_dg) dcyc = i;
    end
    chk("t2_d_cycle", dcyc, 5);
    chk("t2_c_grants", cg_n, 4);
    ct.vld = 1'b0;
    step();
    step();
    chk("t2_mem7", env_mem[7], 32'hAA);

    // C read then D read on consecutive cycles
    ct = mk(1'b0, 9, '0);
    step();
    dt = mk(1'b0, 20, '0);
    step();
    step();

    // halt while a C read is granted, then dump memory
    ct   = mk(1'b0, 11, '0);
    hreq = 1'b1;
    step();
    step();
    step();
    chk("t4_halt_ack", bus.halt_ack, 1'b1);
    ct = mk(1'b0, 14, '0);
    for (int a = 0; a < 32; a++) begin
      dt = mk(1'b0, a, '0);
      step();
    end
    step();
    hreq = 1'b0;
    step();
    step();

    // reset while a D read is pending
    dt = mk(1'b0, 12, '0);
    step();
    rst = 1'b1;
    model_reset();
    ct.vld = 1'b0;
    dt.vld = 1'b0;
    step();
    rst = 1'b0;
    dt = mk(1'b0, 5, '0);
    step();
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (!ct.vld && $urandom_range(0, 1) == 1)
        ct = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom);
      if (!dt.vld && $urandom_range(0, 1) == 1)
        dt = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 15) == 0) hreq = !hreq;
      step();
    end
    ct.vld = 1'b0;
    dt.vld = 1'b0;
    hreq   = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
